// File: rtl/alu_rr_sched.sv
// alu_rr_sched: two-requester round-robin scheduler in front of a shared
// combinational ALU (ADD/SUB/AND/OR). Requests are accepted over valid/ready.
// Operands are held on alu_* for ALU_LAT cycles, and the captured result is
// then returned on the owner's response channel.
// Optional feature macro: ALU_RR_SCHED_STATS_EN adds stat_cnt0/stat_cnt1/stat_wait.
module alu_rr_sched #(
  parameter int unsigned W         = 4,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req0_op,
  input  logic [1:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_cout,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_cout,
  output logic         busy,
  output logic         owner
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  output logic [7:0]   stat_cnt0,
  output logic [7:0]   stat_cnt1,
  output logic [7:0]   stat_wait
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic       PRIO_BIT = 1'(PRIO_INIT);
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [1:0]   alu_op_q, alu_op_d;
  logic [W-1:0] rsp_res_q, rsp_res_d;
  logic         rsp_cout_q, rsp_cout_d;

  logic         accept;
  logic         grant_idx;

  assign accept    = |(req_valid & req_ready);
  assign grant_idx = req_ready[1];

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= PRIO_BIT;
      owner_q    <= PRIO_BIT;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_res_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_res_q  <= rsp_res_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  // Next-state: grant latch in IDLE, latency countdown and capture in EXEC,
  // owner handshake and pointer hand-off in RESP
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_res_d  = rsp_res_q;
    rsp_cout_d = rsp_cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
          owner_d = grant_idx;
          cnt_d   = CNT_INIT;
          if (grant_idx) begin
            alu_a_d  = req1_a;
            alu_b_d  = req1_b;
            alu_op_d = req1_op;
          end else begin
            alu_a_d  = req0_a;
            alu_b_d  = req0_b;
            alu_op_d = req0_op;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d   = S_RESP;
          rsp_res_d = alu_res;
          // carry is only meaningful for ADD/SUB (op[1] == 0)
          rsp_cout_d = alu_cout & ~alu_op_q[1];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = S_IDLE;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pointer-first grant in IDLE, one-hot response valid in RESP
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (rst_n && (state_q == S_IDLE)) begin
      if (req_valid[ptr_q]) begin
        req_ready[ptr_q] = 1'b1;
      end else if (req_valid[~ptr_q]) begin
        req_ready[~ptr_q] = 1'b1;
      end
    end
    if (state_q == S_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_res  = rsp_res_q;
  assign rsp_cout = rsp_cout_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [7:0] stat_cnt0_q, stat_cnt1_q, stat_wait_q;
  logic       rsp_done;
  logic       lost_arb;

  assign rsp_done = (state_q == S_RESP) && rsp_ready[owner_q];
  // both valid in IDLE means exactly one of them was refused this cycle
  assign lost_arb = (state_q == S_IDLE) && (req_valid == 2'b11);

  // Saturating completion and arbitration-loss counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
      stat_wait_q <= '0;
    end else begin
      if (rsp_done && !owner_q && (stat_cnt0_q != '1)) stat_cnt0_q <= stat_cnt0_q + 8'd1;
      if (rsp_done &&  owner_q && (stat_cnt1_q != '1)) stat_cnt1_q <= stat_cnt1_q + 8'd1;
      if (lost_arb && (stat_wait_q != '1))             stat_wait_q <= stat_wait_q + 8'd1;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
  assign stat_wait = stat_wait_q;
`endif

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Two-requester round-robin scheduler that shares one external 4-bit combinational ALU (ADD/SUB/AND/OR, op codes 0/1/2/3).
- Accepts operand/op requests over valid/ready handshakes and drives the shared ALU for ALU_LAT cycles.
- Captures res/cout and returns them to the owning requester over a valid/ready response channel.
- Sits between CPU-side requesters and the ALU datapath.

Parameters:
- W, 4, operand/result width; must match the ALU.
- ALU_LAT, 1, number of EXEC cycles ALU inputs are held before capture; legal range 1..15.
- PRIO_INIT, 0, requester index holding priority after reset (0 or 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept, one-hot or zero.
- req0_a, req0_b  in  W  requester 0 operands.
- req1_a, req1_b  in  W  requester 1 operands.
- req0_op, req1_op  in  2  operation codes: 0 ADD, 1 SUB, 2 AND, 3 OR.
- alu_a, alu_b  out  W  registered operands to the shared ALU.
- alu_op  out  2  registered op to the shared ALU.
- alu_res  in  W  ALU result.
- alu_cout  in  1  ALU carry-out.
- rsp_valid  out  2  per-requester response valid, one-hot or zero.
- rsp_ready  in  2  per-requester response accept.
- rsp_res  out  W  captured result.
- rsp_cout  out  1  captured carry.
- busy  out  1  high whenever the state is not IDLE.
- owner  out  1  index of the current or last granted requester.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; priority pointer = PRIO_INIT.
  - alu_a/alu_b/alu_op = 0; rsp_valid = 0; rsp_res = 0; rsp_cout = 0; busy = 0; owner = PRIO_INIT.
  - req_ready = 0 while rst_n is low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. It is asserted for one requester only:
    - the pointer requester if its req_valid is high;
    - otherwise the other requester if its req_valid is high;
    - otherwise neither.
  - On the clock edge where req_valid & req_ready is true:
    - latch that requester's a/b/op into alu_a/alu_b/alu_op;
    - set owner; load the latency counter with ALU_LAT-1; go to EXEC.
- EXEC:
  - alu_* held stable; req_ready = 0.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, capture at the clock edge:
    - rsp_res = alu_res;
    - rsp_cout = alu_cout when alu_op is 0 or 1, else 0 (forced for AND/OR);
    - go to RESP.
- RESP:
  - rsp_valid[owner] = 1; rsp_res and rsp_cout are stable until handshake completion.
  - rsp_ready of the non-owner is ignored.
  - On rsp_ready[owner]: clear rsp_valid, set pointer = ~owner, go to IDLE.
- Latency: request accepted at edge N → rsp_valid high in the cycle after edge N+ALU_LAT. With ALU_LAT=1, that is 2 cycles after acceptance.
- Throughput: at most 1 op per ALU_LAT+2 cycles per the shared ALU.
- Fairness:
  - The pointer only changes on response completion.
  - With both requesters continuously valid, grants alternate strictly.
- Simultaneous req_valid on both in IDLE: the pointer requester wins; the other waits, with req_ready low and its inputs ignored.
- A requester must hold a/b/op stable while req_valid is high and not accepted; the block samples them only at acceptance.
- A requester dropping req_valid before acceptance is legal: no grant and no state change.
- Backpressure in RESP is unbounded: no new grant and no change on alu_*.
- Arithmetic:
  - SUB is A + ~B + 1 per the ALU.
  - The block does not modify alu_res and only masks cout for AND/OR.
- Reset asserted mid-EXEC or mid-RESP: the transaction is lost with no response, and all outputs take reset values asynchronously.

Optional Feature:
- Macro: ALU_RR_SCHED_STATS_EN.
- When defined, adds outputs stat_cnt0 and stat_cnt1, each 8 bits wide.
  - Each counts completed response handshakes for its requester.
  - Counters saturate at 255 and reset to 0.
- Adds output stat_wait, 8 bits wide.
  - Counts cycles in IDLE where a requester had req_valid high but was not granted because the other requester won.
  - Saturates at 255.
- When not defined, none of these ports or registers exist, and behaviour is otherwise identical.

Test Plan:
- Requester 0 with ALU_LAT=1, A=3, B=4, op 0,1,2,3 in turn, rsp_ready always high → rsp_res/cout = 7/0, F/0, 0/0, 7/0; rsp_valid exactly 2 cycles after each accept.
- Requester 1 with A=11, B=12: op0 → res 7, cout 1; op1 → res F, cout 0; op2 → res 8, cout 0 (ALU raw cout ignored); op3 → res F, cout 0.
- Requester 0 with A=0, B=15, op1 → res 1, cout 0. Same operands with ALU_LAT=3 → alu_* stable for 3 cycles, rsp_valid 4 cycles after accept.
- Both req_valid held high from reset with PRIO_INIT=0 for 4 ops → grant order 0,1,0,1. Each loser sees req_ready low until the previous response completes.
- Hold rsp_ready[owner]=0 for 5 cycles in RESP → rsp_valid and rsp_res unchanged and no req_ready. Asserting rsp_ready of the non-owner has no effect.
- Drop rst_n during EXEC → busy, rsp_valid, and alu_* go to 0 immediately with no clock. After release the block is in IDLE, pointer = PRIO_INIT, and the next request completes normally.
